// File: rtl/pl_alu_pkg.sv
// Shared control-bit indices, result-select encoding and modular helpers for the execute-stage ALU.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pl_alu_pkg;

    localparam int CTRL_W        = 15;
    localparam int CTRL_ADD      = 14;
    localparam int CTRL_OR_OP    = 13;
    localparam int CTRL_NOT_OP   = 12;
    localparam int CTRL_AND_BW   = 11;
    localparam int CTRL_OR_BW    = 10;
    localparam int CTRL_NOT_BW   = 9;
    localparam int CTRL_AND_OP   = 8;
    localparam int CTRL_CARRY_IN = 7;
    localparam int CTRL_OP2_CMPL = 6;
    localparam int CTRL_JUMP     = 5;
    localparam int CTRL_CMP      = 4;
    localparam int CTRL_SHL      = 3;
    localparam int CTRL_LGCL_BW  = 2;
    localparam int CTRL_STORE    = 1;
    localparam int CTRL_MUL      = 0;

    typedef enum logic [2:0] {
        SEL_MUL,
        SEL_ADD,
        SEL_SHL,
        SEL_LOGIC,
        SEL_NONE
    } alu_sel_e;

    // One conditional subtraction: exact reduction whenever x < 2*m.
    function automatic logic [8:0] mod_csub(input logic [8:0] x, input logic [8:0] m);
        return (x >= m) ? (x - m) : x;
    endfunction

endpackage

// File: rtl/pl_alu_if.sv
// Operand/control/result bundle between the execute-stage sequencer and one ALU copy.
// Latency: n/a (wires only).
// Backpressure: none; alu_en is a capture enable, outputs hold while it is low.
interface pl_alu_if;
    import pl_alu_pkg::*;

    logic              alu_en;
    logic [7:0]        op1_in;
    logic [7:0]        op2_in;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [7:0]        dout;
    logic              cout;
    logic              comp_gt;
    logic              comp_lt;
    logic              comp_eq;

    modport master (
        output alu_en, op1_in, op2_in, alu_ctrl,
        input  dout, cout, comp_gt, comp_lt, comp_eq
    );

    modport slave (
        input  alu_en, op1_in, op2_in, alu_ctrl,
        output dout, cout, comp_gt, comp_lt, comp_eq
    );
endinterface

// File: rtl/pl_mod_reduce.sv
// Combinational 16-bit value mod MODULUS (MODULUS in 129..256) by shifted conditional subtraction.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module pl_mod_reduce #(
    parameter logic [8:0] MODULUS = 9'd256
) (
    input  logic [15:0] value,
    output logic [7:0]  result
);
    logic [16:0] acc;
    logic [16:0] mk;

    // Restoring division keeping only the remainder: since MODULUS >= 128,
    // value < 2*(MODULUS<<8), so nine stages from shift 8 down to 0 suffice.
    always_comb begin
        acc = {1'b0, value};
        mk  = '0;
        for (int k = 8; k >= 0; k--) begin
            mk = {8'd0, MODULUS} << k;
            if (acc >= mk) begin
                acc = acc - mk;
            end
        end
    end

    // Remainder is below MODULUS <= 256, so it fits in eight bits.
    assign result = acc[7:0];

    logic unused_hi;
    assign unused_hi = &{1'b0, acc[16:8]};
endmodule

// File: rtl/pl_alu_unit.sv
// 8-bit execute-stage ALU, integer (MODULAR=0) or residue mod MODULUS (MODULAR=1); mul only with PL_ALU_MUL_EN.
// Latency: 1 cycle, outputs registered at the edge that samples alu_en=1.
// Backpressure: none; alu_en=0 holds every output.
module pl_alu_unit
    import pl_alu_pkg::*;
#(
    parameter int         MODULAR = 0,
    parameter logic [8:0] MODULUS = 9'd256
) (
    input  logic     clk,
    input  logic     reset,
    pl_alu_if.slave  bus
);
    logic [CTRL_W-1:0] ctrl;
    logic [7:0]        op1;
    logic [7:0]        op2;
    logic [8:0]        red1;
    logic [8:0]        red2;
    logic [7:0]        a1;
    logic [7:0]        a2;
    logic              mul_req;
    alu_sel_e          sel;

    assign ctrl = bus.alu_ctrl;
    assign op1  = bus.op1_in;
    assign op2  = bus.op2_in;

    // Residue operands: one subtraction reduces any 8-bit value because MODULUS >= 129.
    assign red1 = mod_csub({1'b0, op1}, MODULUS);
    assign red2 = mod_csub({1'b0, op2}, MODULUS);
    assign a1   = (MODULAR != 0) ? red1[7:0] : op1;
    assign a2   = (MODULAR != 0) ? red2[7:0] : op2;

`ifdef PL_ALU_MUL_EN
    assign mul_req = ctrl[CTRL_MUL];
`else
    assign mul_req = 1'b0;
`endif

    // Result source, first match wins.
    always_comb begin
        sel = SEL_NONE;
        if (mul_req) begin
            sel = SEL_MUL;
        end else if (ctrl[CTRL_ADD] || ctrl[CTRL_CMP]) begin
            sel = SEL_ADD;
        end else if (ctrl[CTRL_SHL]) begin
            sel = SEL_SHL;
        end else if (ctrl[CTRL_LGCL_BW]) begin
            sel = SEL_LOGIC;
        end
    end

    // Compare without add is a forced subtract; add honours its own complement/carry bits.
    logic       do_sub;
    logic       cin;
    logic [7:0] b_int;
    logic [8:0] sum_int;

    assign do_sub  = ctrl[CTRL_ADD] ? ctrl[CTRL_OP2_CMPL] : 1'b1;
    assign cin     = ctrl[CTRL_ADD] ? ctrl[CTRL_CARRY_IN] : 1'b1;
    assign b_int   = do_sub ? ~a2 : a2;
    assign sum_int = {1'b0, a1} + {1'b0, b_int} + {8'd0, cin};

    // Modular add/sub/shift: operands are already below MODULUS, so every
    // intermediate is below 2*MODULUS and a single conditional subtract closes it.
    logic [8:0] neg2;
    logic [8:0] m_add;
    logic [8:0] m_sub;
    logic [8:0] m_shl;

    assign neg2  = (a2 == 8'd0) ? 9'd0 : (MODULUS - {1'b0, a2});
    assign m_add = mod_csub({1'b0, a1} + {1'b0, a2}, MODULUS);
    assign m_sub = mod_csub({1'b0, a1} + neg2, MODULUS);
    assign m_shl = mod_csub({a1, 1'b0}, MODULUS);

    // Integer logical (0/1) and bitwise results behind lgcl_or_bitwse_T.
    logic [7:0] logic_res;
    always_comb begin
        logic_res = 8'd0;
        if (ctrl[CTRL_OR_OP]) begin
            logic_res = {7'd0, (a1 != 8'd0) || (a2 != 8'd0)};
        end else if (ctrl[CTRL_NOT_OP]) begin
            logic_res = {7'd0, a1 == 8'd0};
        end else if (ctrl[CTRL_AND_BW]) begin
            logic_res = a1 & a2;
        end else if (ctrl[CTRL_OR_BW]) begin
            logic_res = a1 | a2;
        end else if (ctrl[CTRL_NOT_BW]) begin
            logic_res = ~a1;
        end else if (ctrl[CTRL_AND_OP]) begin
            logic_res = {7'd0, (a1 != 8'd0) && (a2 != 8'd0)};
        end
    end

    logic [7:0] mul_res;
`ifdef PL_ALU_MUL_EN
    logic [15:0] prod;
    assign prod = {8'd0, a1} * {8'd0, a2};
    if (MODULAR != 0) begin : g_mod_mul
        pl_mod_reduce #(.MODULUS(MODULUS)) u_prod_reduce (
            .value  (prod),
            .result (mul_res)
        );
    end else begin : g_int_mul
        assign mul_res = prod[7:0];
        logic unused_prod_hi;
        assign unused_prod_hi = &{1'b0, prod[15:8]};
    end
`else
    assign mul_res = 8'd0;
`endif

    // Next-state result/carry from the selected source.
    logic [7:0] dout_d;
    logic       cout_d;
    always_comb begin
        dout_d = 8'd0;
        cout_d = 1'b0;
        case (sel)
            SEL_MUL: dout_d = mul_res;
            SEL_ADD: begin
                if (MODULAR != 0) begin
                    dout_d = do_sub ? m_sub[7:0] : m_add[7:0];
                end else begin
                    dout_d = sum_int[7:0];
                    cout_d = sum_int[8];
                end
            end
            SEL_SHL: begin
                if (MODULAR != 0) begin
                    dout_d = m_shl[7:0];
                end else begin
                    dout_d = {a1[6:0], 1'b0};
                    cout_d = a1[7];
                end
            end
            SEL_LOGIC: dout_d = (MODULAR != 0) ? 8'd0 : logic_res;
            default:   dout_d = 8'd0;
        endcase
    end

    // Output registers: capture on alu_en, otherwise hold; async clear.
    logic [7:0] dout_q;
    logic       cout_q;
    logic       gt_q;
    logic       lt_q;
    logic       eq_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= 8'd0;
            cout_q <= 1'b0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else if (bus.alu_en) begin
            dout_q <= dout_d;
            cout_q <= cout_d;
            gt_q   <= a1 > a2;
            lt_q   <= a1 < a2;
            eq_q   <= a1 == a2;
        end
    end

    assign bus.dout    = dout_q;
    assign bus.cout    = cout_q;
    assign bus.comp_gt = gt_q;
    assign bus.comp_lt = lt_q;
    assign bus.comp_eq = eq_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, ctrl[CTRL_JUMP], ctrl[CTRL_STORE], ctrl[CTRL_MUL],
                           red1[8], red2[8], m_add[8], m_sub[8], m_shl[8]};
endmodule

// File: tb/tb_pl_alu_unit.sv
// Bench for pl_alu_unit: integer, mod-129 and mod-256 copies driven in lockstep.
// Latency: checks outputs one edge after each enabled sample.
// Backpressure: n/a.
module tb_pl_alu_unit;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    bit   chk_on;

`ifdef PL_ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    localparam logic [14:0] C_ADD   = 15'h4000;
    localparam logic [14:0] C_SUB   = 15'h40C0;
    localparam logic [14:0] C_CMP   = 15'h0010;
    localparam logic [14:0] C_SHL   = 15'h0008;
    localparam logic [14:0] C_ANDOP = 15'h0104;
    localparam logic [14:0] C_NOTOP = 15'h1004;
    localparam logic [14:0] C_ORBW  = 15'h0404;
    localparam logic [14:0] C_ANDBW = 15'h0804;
    localparam logic [14:0] C_NOTBW = 15'h0204;
    localparam logic [14:0] C_MUL   = 15'h0001;
    localparam logic [14:0] C_JMP   = 15'h0020;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pl_alu_if if_int ();
    pl_alu_if if_m129 ();
    pl_alu_if if_m256 ();

    pl_alu_unit #(.MODULAR(0), .MODULUS(9'd256)) u_int  (.clk(clk), .reset(rst_n), .bus(if_int));
    pl_alu_unit #(.MODULAR(1), .MODULUS(9'd129)) u_m129 (.clk(clk), .reset(rst_n), .bus(if_m129));
    pl_alu_unit #(.MODULAR(1), .MODULUS(9'd256)) u_m256 (.clk(clk), .reset(rst_n), .bus(if_m256));

    int cfg_mod [3] = '{0, 1, 1};
    int cfg_m   [3] = '{256, 129, 256};

    logic [7:0] act_d [3];
    logic [3:0] act_f [3];
    assign act_d[0] = if_int.dout;
    assign act_d[1] = if_m129.dout;
    assign act_d[2] = if_m256.dout;
    assign act_f[0] = {if_int.cout,  if_int.comp_gt,  if_int.comp_lt,  if_int.comp_eq};
    assign act_f[1] = {if_m129.cout, if_m129.comp_gt, if_m129.comp_lt, if_m129.comp_eq};
    assign act_f[2] = {if_m256.cout, if_m256.comp_gt, if_m256.comp_lt, if_m256.comp_eq};

    // Reference ALU written from the arithmetic rules; f = {cout, gt, lt, eq}.
    function automatic void alu_model(input int modular, input int m, input int o1, input int o2,
                                      input logic [14:0] c, output logic [7:0] d, output logic [3:0] f);
        int r1, r2, res, co, cin;
        bit sub;
        r1 = modular != 0 ? o1 % m : o1;
        r2 = modular != 0 ? o2 % m : o2;
        res = 0;
        co = 0;
        if (MUL_ON && c[0]) begin
            res = modular != 0 ? (r1 * r2) % m : (o1 * o2) % 256;
        end else if (c[14] || c[4]) begin
            sub = c[14] ? c[6] : 1'b1;
            cin = c[14] ? int'(c[7]) : 1;
            if (modular != 0) begin
                res = sub ? (r1 + m - r2) % m : (r1 + r2) % m;
            end else begin
                res = o1 + (sub ? 255 - o2 : o2) + cin;
                co  = res / 256;
                res = res % 256;
            end
        end else if (c[3]) begin
            if (modular != 0) begin
                res = (2 * r1) % m;
            end else begin
                res = (2 * o1) % 256;
                co  = o1 / 128;
            end
        end else if (c[2] && modular == 0) begin
            if (c[13])      res = (o1 != 0 || o2 != 0) ? 1 : 0;
            else if (c[12]) res = (o1 == 0) ? 1 : 0;
            else if (c[11]) res = o1 & o2;
            else if (c[10]) res = o1 | o2;
            else if (c[9])  res = 255 - o1;
            else if (c[8])  res = (o1 != 0 && o2 != 0) ? 1 : 0;
        end
        d = res[7:0];
        f = {co[0], r1 > r2, r1 < r2, r1 == r2};
    endfunction

    logic [7:0] exp_d [3];
    logic [3:0] exp_f [3];

    // Model state: registered like the DUT, cleared asynchronously.
    always @(posedge clk or negedge rst_n) begin : model_proc
        logic [7:0] d;
        logic [3:0] f;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                exp_d[i] <= 8'd0;
                exp_f[i] <= 4'd0;
            end
        end else if (if_int.alu_en) begin
            for (int i = 0; i < 3; i++) begin
                alu_model(cfg_mod[i], cfg_m[i], int'(if_int.op1_in), int'(if_int.op2_in),
                          if_int.alu_ctrl, d, f);
                exp_d[i] <= d;
                exp_f[i] <= f;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all three copies against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_dout[%0d]", i), act_d[i], exp_d[i]);
                chk($sformatf("model_flags[%0d]", i), {4'h0, act_f[i]}, {4'h0, exp_f[i]});
            end
        end
    end

    task automatic drive(input logic en, input logic [7:0] o1, input logic [7:0] o2, input logic [14:0] c);
        if_int.alu_en  = en; if_int.op1_in  = o1; if_int.op2_in  = o2; if_int.alu_ctrl  = c;
        if_m129.alu_en = en; if_m129.op1_in = o1; if_m129.op2_in = o2; if_m129.alu_ctrl = c;
        if_m256.alu_en = en; if_m256.op1_in = o1; if_m256.op2_in = o2; if_m256.alu_ctrl = c;
    endtask

    // Apply one vector at the falling edge, let it be captured, settle past the edge.
    task automatic step(input logic en, input logic [7:0] o1, input logic [7:0] o2, input logic [14:0] c);
        @(negedge clk);
        drive(en, o1, o2, c);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_dout[%0d]", name, i), act_d[i], 8'h00);
            chk($sformatf("%s_flags[%0d]", name, i), {4'h0, act_f[i]}, 8'h00);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_on  = 1'b0;
        rst_n   = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 15'h0);
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Capture and hold.
        step(1'b1, 8'h05, 8'h03, C_ADD);
        chk("add_int", if_int.dout, 8'h08);
        chk("add_m129", if_m129.dout, 8'h08);
        step(1'b0, 8'hAA, 8'h55, C_SHL);
        chk("hold_int", if_int.dout, 8'h08);
        chk("hold_m256", if_m256.dout, 8'h08);

        // Integer carry / subtract / compare.
        step(1'b1, 8'hF0, 8'h20, C_ADD);
        chk("carry_dout", if_int.dout, 8'h10);
        chk("carry_cout", {7'd0, if_int.cout}, 8'h01);
        chk("carry_m129", if_m129.dout, 8'd14);
        step(1'b1, 8'h10, 8'h01, C_SUB);
        chk("sub_dout", if_int.dout, 8'h0F);
        chk("sub_cout", {7'd0, if_int.cout}, 8'h01);
        step(1'b1, 8'h22, 8'h33, C_CMP);
        chk("cmp_flags", {5'd0, if_int.comp_gt, if_int.comp_lt, if_int.comp_eq}, 8'b010);
        chk("cmp_dout", if_int.dout, 8'hEF);

        // Shift / logical / bitwise.
        step(1'b1, 8'h81, 8'h00, C_SHL);
        chk("shl_dout", if_int.dout, 8'h02);
        chk("shl_cout", {7'd0, if_int.cout}, 8'h01);
        chk("shl_m129", if_m129.dout, 8'h00);
        step(1'b1, 8'h00, 8'h07, C_ANDOP);
        chk("andop", if_int.dout, 8'h00);
        step(1'b1, 8'h00, 8'h07, C_NOTOP);
        chk("notop", if_int.dout, 8'h01);
        chk("notop_m129", if_m129.dout, 8'h00);
        step(1'b1, 8'hF0, 8'h3C, C_ANDBW);
        chk("andbw", if_int.dout, 8'h30);
        step(1'b1, 8'hF0, 8'h3C, C_ORBW);
        chk("orbw", if_int.dout, 8'hFC);
        step(1'b1, 8'h0F, 8'h00, C_NOTBW);
        chk("notbw", if_int.dout, 8'hF0);

        // Modular M=129 and M=256 equivalence.
        step(1'b1, 8'd100, 8'd50, C_ADD);
        chk("madd_m129", if_m129.dout, 8'd21);
        chk("madd_m256", if_m256.dout, 8'd150);
        step(1'b1, 8'd10, 8'd20, C_SUB);
        chk("msub_m129", if_m129.dout, 8'd119);
        chk("msub_m256", if_m256.dout, 8'hF6);
        step(1'b1, 8'd100, 8'd0, C_SHL);
        chk("mshl_m129", if_m129.dout, 8'd71);
        step(1'b1, 8'd200, 8'd0, C_ADD);
        chk("mred_m129", if_m129.dout, 8'd71);
        chk("mred_gt", {7'd0, if_m129.comp_gt}, 8'h01);
        step(1'b1, 8'd0, 8'd200, C_CMP);
        chk("mcmp_m129", if_m129.dout, 8'd58);

        // Multiply, or its absence.
        step(1'b1, 8'd100, 8'd100, C_MUL);
        if (MUL_ON) chk("mul_m129", if_m129.dout, 8'd67);
        else        chk("nomul_m129", if_m129.dout, 8'd0);
        step(1'b1, 8'h10, 8'h11, C_MUL);
        if (MUL_ON) chk("mul_int", if_int.dout, 8'h10);
        else        chk("nomul_int", if_int.dout, 8'h00);
        step(1'b1, 8'h10, 8'h11, C_MUL | C_ADD);
        chk("mul_prio", if_int.dout, MUL_ON ? 8'h10 : 8'h21);
        step(1'b1, 8'h44, 8'h11, C_JMP);
        chk("jump_none", if_int.dout, 8'h00);

        // Asynchronous reset between edges.
        step(1'b1, 8'h05, 8'h03, C_ADD);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 8'h00, 15'h0);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
